// File: rtl/edge_gen.sv
// Edge generator: filters the buffered neighbourhood candidates of a new event by
// Chebyshev radius and temporal window, then streams one edge beat per match.
module edge_gen #(
    parameter int EVT_W      = 72,
    parameter int MAX_DEGREE = 16,
    parameter int IDX_W      = $clog2(MAX_DEGREE),
    parameter int CNT_W      = $clog2(MAX_DEGREE + 1)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [EVT_W-1:0]            in_evt,
    input  logic [MAX_DEGREE*EVT_W-1:0] in_cand,
    input  logic [9:0]                  cfg_r,
    input  logic [31:0]                 cfg_t_win,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_idx,
    output logic signed [10:0]          out_dx,
    output logic signed [10:0]          out_dy,
    output logic [31:0]                 out_dt,
    output logic                        out_last,
    output logic                        evt_done,
    output logic [CNT_W-1:0]            edge_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_MASK, S_EMIT, S_DONE} state_t;

    function automatic logic signed [10:0] f_diff(input logic [9:0] a, input logic [9:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic [10:0] f_abs(input logic signed [10:0] v);
        return v[10] ? -v : v;
    endfunction

    function automatic logic f_match(
        input logic        c_vld,
        input logic [9:0]  c_x,
        input logic [9:0]  c_y,
        input logic [31:0] c_t,
        input logic [9:0]  n_x,
        input logic [9:0]  n_y,
        input logic [31:0] n_t,
        input logic [9:0]  r,
        input logic [31:0] tw
    );
        logic signed [10:0] dx;
        logic signed [10:0] dy;
        logic [31:0]        dt;
        logic               t_ok;
        logic               s_ok;
        dx   = f_diff(c_x, n_x);
        dy   = f_diff(c_y, n_y);
        dt   = n_t - c_t;
        t_ok = (n_t >= c_t) && (dt <= tw);
        s_ok = (f_abs(dx) <= {1'b0, r}) && (f_abs(dy) <= {1'b0, r});
        return c_vld && t_ok && s_ok && !((dx == '0) && (dy == '0) && (dt == '0));
    endfunction

    function automatic logic [IDX_W-1:0] f_lowest(input logic [MAX_DEGREE-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = MAX_DEGREE - 1; k >= 0; k--) begin
            if (m[k]) idx = IDX_W'(k);
        end
        return idx;
    endfunction

    state_t                        r_state;
    state_t                        w_next;
    logic                          w_accept;
    logic [9:0]                    r_nx;
    logic [9:0]                    r_ny;
    logic [31:0]                   r_nt;
    logic [MAX_DEGREE*EVT_W-1:0]   r_cand;
    logic [9:0]                    r_r;
    logic [31:0]                   r_tw;
    logic [MAX_DEGREE-1:0]         w_match;
    logic [MAX_DEGREE-1:0]         r_mask;
    logic [MAX_DEGREE-1:0]         w_rem;
    logic [MAX_DEGREE-1:0]         w_sel_mask;
    logic [IDX_W-1:0]              w_sel_idx;
    logic [9:0]                    w_sel_x;
    logic [9:0]                    w_sel_y;
    logic [31:0]                   w_sel_t;
    logic                          w_sel_last;
    logic                          w_load;
    logic                          w_unused;
    logic                          r_in_ready;
    logic                          r_out_valid;
    logic [IDX_W-1:0]              r_out_idx;
    logic signed [10:0]            r_out_dx;
    logic signed [10:0]            r_out_dy;
    logic [31:0]                   r_out_dt;
    logic                          r_out_last;
    logic                          r_evt_done;
    logic [CNT_W-1:0]              r_cnt;

    assign w_accept = in_valid && r_in_ready;

    // Reserved bits, pol and the new event's vld never take part in matching.
    always_comb begin
        w_unused = ^in_evt[EVT_W-1:52];
        for (int k = 0; k < MAX_DEGREE; k++) begin
            w_unused = w_unused ^ (^r_cand[k*EVT_W+52 +: EVT_W-52]);
        end
    end

    // Accept stage: capture the event and its configuration; cfg is frozen from here on.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_nx   <= in_evt[51:42];
            r_ny   <= in_evt[41:32];
            r_nt   <= in_evt[31:0];
            r_cand <= in_cand;
            r_r    <= cfg_r;
            r_tw   <= cfg_t_win;
        end
    end

    // Mask stage: per-slot radius/window test on the captured data.
    always_comb begin
        w_match = '0;
        for (int k = 0; k < MAX_DEGREE; k++) begin
            w_match[k] = f_match(r_cand[k*EVT_W+53], r_cand[k*EVT_W+42 +: 10],
                                 r_cand[k*EVT_W+32 +: 10], r_cand[k*EVT_W +: 32],
                                 r_nx, r_ny, r_nt, r_r, r_tw);
        end
    end

    // Next beat comes from the fresh mask in MASK, or from the mask minus the beat just taken.
    assign w_rem      = r_mask & ~(MAX_DEGREE'(1) << r_out_idx);
    assign w_sel_mask = (r_state == S_MASK) ? w_match : w_rem;
    assign w_sel_idx  = f_lowest(w_sel_mask);
    assign w_sel_x    = r_cand[w_sel_idx*EVT_W+42 +: 10];
    assign w_sel_y    = r_cand[w_sel_idx*EVT_W+32 +: 10];
    assign w_sel_t    = r_cand[w_sel_idx*EVT_W +: 32];
    assign w_sel_last = ((w_sel_mask & ~(MAX_DEGREE'(1) << w_sel_idx)) == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_MASK;
            S_MASK: begin
                w_next = (|w_match) ? S_EMIT : S_DONE;
                w_load = |w_match;
            end
            S_EMIT: if (out_ready) begin
                w_next = r_out_last ? S_DONE : S_EMIT;
                w_load = !r_out_last;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Emit stage: registered handshake flags and edge payload.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_evt_done  <= 1'b0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_out_idx   <= '0;
            r_out_dx    <= '0;
            r_out_dy    <= '0;
            r_out_dt    <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == S_IDLE);
            r_out_valid <= (w_next == S_EMIT);
            r_evt_done  <= (w_next == S_DONE);
            if (w_accept) r_cnt <= '0;
            if (r_state == S_MASK) r_mask <= w_match;
            if ((r_state == S_EMIT) && out_ready) begin
                r_mask <= w_rem;
                r_cnt  <= r_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_out_idx  <= w_sel_idx;
                r_out_dx   <= f_diff(w_sel_x, r_nx);
                r_out_dy   <= f_diff(w_sel_y, r_ny);
                r_out_dt   <= r_nt - w_sel_t;
                r_out_last <= w_sel_last;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_dx    = r_out_dx;
    assign out_dy    = r_out_dy;
    assign out_dt    = r_out_dt;
    assign out_last  = r_out_last;
    assign evt_done  = r_evt_done;
    assign edge_cnt  = r_cnt;

endmodule

// File: tb/tb_edge_gen.sv
// Bench for edge_gen: directed and random events checked against a list-based
// reference of expected edges, with optional random backpressure.
module tb_edge_gen;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [71:0]   in_evt = '0;
    logic [1151:0] in_cand = '0;
    logic [9:0]    cfg_r = '0;
    logic [31:0]   cfg_t_win = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_idx;
    logic [10:0]   out_dx;
    logic [10:0]   out_dy;
    logic [31:0]   out_dt;
    logic          out_last;
    logic          evt_done;
    logic [4:0]    edge_cnt;

    edge_gen dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_evt(in_evt), .in_cand(in_cand), .cfg_r(cfg_r), .cfg_t_win(cfg_t_win),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_dx(out_dx), .out_dy(out_dy), .out_dt(out_dt), .out_last(out_last),
        .evt_done(evt_done), .edge_cnt(edge_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     idx;
        int     dx;
        int     dy;
        longint dt;
        bit     last;
    } beat_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    beat_t       exp_q[$];
    logic [71:0] cand[16];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {in_ready, out_valid, out_idx, out_dx, out_dy, out_dt, out_last,
                  evt_done, edge_cnt}, '0);
    endtask

    function automatic int clamp10(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    function automatic logic [71:0] mk(input bit v, input int x, input int y, input logic [31:0] t);
        return {18'($urandom), v, 1'($urandom), 10'(x), 10'(y), t};
    endfunction

    // Reference: list every valid candidate that lies within the window and radius, in slot order.
    function automatic void build_expected(input logic [71:0] ne, input int r, input longint tw);
        longint nt, ct;
        int dx, dy;
        exp_q.delete();
        nt = longint'(ne[31:0]);
        for (int k = 0; k < 16; k++) begin
            ct = longint'(cand[k][31:0]);
            dx = int'(cand[k][51:42]) - int'(ne[51:42]);
            dy = int'(cand[k][41:32]) - int'(ne[41:32]);
            if (cand[k][53] && ct <= nt && (nt - ct) <= tw &&
                (dx < 0 ? -dx : dx) <= r && (dy < 0 ? -dy : dy) <= r &&
                !(dx == 0 && dy == 0 && nt == ct))
                exp_q.push_back('{k, dx, dy, nt - ct, 1'b0});
        end
        if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
    endfunction

    task automatic pack_cand();
        for (int k = 0; k < 16; k++) in_cand[k*72 +: 72] = cand[k];
    endtask

    task automatic fill_invalid(input logic [71:0] ne);
        for (int k = 0; k < 16; k++)
            cand[k] = mk(1'b0, int'(ne[51:42]), int'(ne[41:32]), ne[31:0] - 32'd1);
    endtask

    task automatic fill_all_match(input logic [71:0] ne, input int r, input int tw);
        for (int k = 0; k < 16; k++)
            cand[k] = mk(1'b1,
                         clamp10(int'(ne[51:42]) + int'($urandom_range(0, 2*r)) - r),
                         clamp10(int'(ne[41:32]) + int'($urandom_range(0, 2*r)) - r),
                         ne[31:0] - 32'($urandom_range(1, tw)));
    endtask

    task automatic fill_random(input logic [71:0] ne);
        int x, y;
        for (int k = 0; k < 16; k++) begin
            x = clamp10(int'(ne[51:42]) + int'($urandom_range(0, 12)) - 6);
            y = clamp10(int'(ne[41:32]) + int'($urandom_range(0, 12)) - 6);
            if ($urandom % 6 == 0) x = int'($urandom_range(0, 1023));
            if ($urandom % 8 == 0)
                cand[k] = mk(1'b1, int'(ne[51:42]), int'(ne[41:32]), ne[31:0]);
            else
                cand[k] = mk($urandom % 4 != 0, x, y, ne[31:0] + 32'd100 - 32'($urandom_range(0, 800)));
        end
    endtask

    task automatic run_event(input logic [71:0] ne, input logic [9:0] r, input logic [31:0] tw,
                             input bit bp, input string tag);
        int n_exp;
        int cyc;
        bit done;
        logic [10:0] edx, edy;
        build_expected(ne, int'(r), longint'(tw));
        n_exp = exp_q.size();
        for (int i = 0; i < 50 && in_ready !== 1'b1; i++) step();
        chk({tag, "/ready"}, in_ready, 1);
        in_valid  = 1'b1;
        in_evt    = ne;
        pack_cand();
        cfg_r     = r;
        cfg_t_win = tw;
        out_ready = bp ? 1'($urandom) : 1'b1;
        step();
        // Inputs and cfg are scrambled once the event is accepted.
        in_valid  = 1'($urandom);
        in_evt    = {8'($urandom), $urandom, $urandom};
        for (int w = 0; w < 36; w++) in_cand[w*32 +: 32] = $urandom;
        cfg_r     = 10'($urandom);
        cfg_t_win = $urandom;
        chk({tag, "/mask_cycle"}, {in_ready, out_valid, evt_done}, 0);
        step();
        cyc  = 2;
        done = 0;
        while (!done && cyc < 300) begin
            out_ready = bp ? 1'($urandom) : 1'b1;
            chk({tag, "/in_ready_busy"}, in_ready, 0);
            if (cyc == 2) chk({tag, "/first_valid"}, out_valid, n_exp > 0);
            if (evt_done === 1'b1) begin
                chk({tag, "/valid_at_done"}, out_valid, 0);
                chk({tag, "/edge_cnt"}, edge_cnt, n_exp);
                chk({tag, "/beats_missing"}, exp_q.size(), 0);
                if (!bp) chk({tag, "/done_cycle"}, cyc, n_exp + 2);
                done     = 1;
                in_valid = 1'b0;
            end else begin
                if (out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk({tag, "/extra_beat"}, out_valid, 0);
                    end else begin
                        edx = 11'(exp_q[0].dx);
                        edy = 11'(exp_q[0].dy);
                        chk({tag, "/idx"}, out_idx, exp_q[0].idx);
                        chk({tag, "/dx"}, out_dx, edx);
                        chk({tag, "/dy"}, out_dy, edy);
                        chk({tag, "/dt"}, out_dt, exp_q[0].dt);
                        chk({tag, "/last"}, out_last, exp_q[0].last);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                in_valid = 1'($urandom);
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        if (!done) chk({tag, "/evt_done_timeout"}, done, 1);
        chk({tag, "/ready_return"}, in_ready, 1);
        chk({tag, "/done_pulse"}, evt_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] ne;

        // Reset and idle
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_zero("reset_outputs");
        end
        rstn = 1'b1;
        step();
        chk("in_ready_after_release", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_no_valid", {out_valid, evt_done}, 0);
        end

        // All candidates invalid
        ne = mk(1'b1, 200, 300, 32'd5000);
        fill_invalid(ne);
        run_event(ne, 10'd5, 32'd1000, 1'b0, "all_invalid");

        // Mixed matches
        ne = mk(1'b1, 100, 50, 32'd1000);
        fill_invalid(ne);
        cand[2]  = mk(1'b1, 102, 49, 32'd800);
        cand[5]  = mk(1'b1, 104, 50, 32'd900);
        cand[9]  = mk(1'b1, 97, 53, 32'd500);
        cand[12] = mk(1'b1, 100, 50, 32'd1200);
        run_event(ne, 10'd3, 32'd500, 1'b0, "mixed");

        // Self-match exclusion and window edges
        ne = mk(1'b1, 400, 600, 32'd5000);
        fill_invalid(ne);
        cand[0] = mk(1'b1, 400, 600, 32'd5000);
        cand[1] = mk(1'b1, 400, 600, 32'd4999);
        run_event(ne, 10'd3, 32'd0, 1'b0, "self_tw0");
        run_event(ne, 10'd3, 32'd1, 1'b0, "self_tw1");

        // Backpressure with all slots matching
        ne = mk(1'b1, 500, 500, 32'd100000);
        fill_all_match(ne, 4, 300);
        run_event(ne, 10'd4, 32'd300, 1'b1, "backpressure");

        // Reset during the fifth beat
        ne = mk(1'b1, 700, 20, 32'd80000);
        fill_all_match(ne, 2, 50);
        build_expected(ne, 2, 50);
        in_valid  = 1'b1;
        in_evt    = ne;
        pack_cand();
        cfg_r     = 10'd2;
        cfg_t_win = 32'd50;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("midrst/fifth_beat_valid", out_valid, 1);
        chk("midrst/fifth_beat_idx", out_idx, exp_q[4].idx);
        rstn = 1'b0;
        #1;
        chk_zero("midrst/async_clear");
        for (int i = 0; i < 2; i++) begin
            step();
            chk_zero("midrst/held");
        end
        rstn = 1'b1;
        step();
        chk("midrst/ready_after_release", in_ready, 1);
        chk("midrst/no_done", evt_done, 0);
        ne = mk(1'b1, 0, 1023, 32'd3000);
        fill_random(ne);
        run_event(ne, 10'd5, 32'd400, 1'b0, "after_midrst");

        // Random events with random configuration and backpressure
        for (int n = 0; n < 24; n++) begin
            int x, y;
            logic [9:0] r;
            x  = (n % 5 == 0) ? 0 : ((n % 5 == 1) ? 1023 : int'($urandom_range(0, 1023)));
            y  = int'($urandom_range(0, 1023));
            ne = mk(1'($urandom), x, y, 32'd1000 + $urandom_range(0, 1000000));
            fill_random(ne);
            r  = ($urandom % 8 == 0) ? 10'd1023 : 10'($urandom_range(0, 6));
            run_event(ne, r, 32'($urandom_range(0, 600)), 1'($urandom), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
